data_ram_resp: RTL and testbench

Memory-side responder for the CPU's data load/store port inside Minisopc. It accepts one request at a time from the CPU memory stage, inserts a configurable number of wait states, performs a byte-selectable write or a full-word read, and signals completion with a one-cycle `ready` pulse. While a request is outstanding it raises `stallreq` toward the pipeline control.

---
 rtl/data_ram_resp_pkg.sv | 25 ++
 rtl/data_ram_resp_array.sv | 28 ++
 rtl/data_ram_resp.sv | 135 +++++++++++++
 tb/tb_data_ram_resp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_resp_pkg.sv
// Shared constants and helpers for the data RAM responder.
// DRAM_ALIGN_CHECK_EN enables request rejection (alignment/range).
package data_ram_resp_pkg;

    typedef enum logic [1:0] {
        DramIdle = 2'd0,
        DramWait = 2'd1,
        DramResp = 2'd2
    } dram_state_t;

    localparam logic        RstEnable  = 1'b1;
    localparam logic        RstDisable = 1'b0;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam int          DramWaitW  = 4;

    // Full word needs addr[1:0]==0; a halfword needs an even address.
    function automatic logic misaligned(input logic [1:0] lo, input logic [3:0] sel);
        logic word;
        logic half;
        word = (sel == 4'b1111);
        half = (sel == 4'b0011) || (sel == 4'b1100);
        misaligned = (word && (lo != 2'b00)) || (half && lo[0]);
    endfunction

endpackage

// File: rtl/data_ram_resp_array.sv
// Single-port word storage with 4 byte-write lanes and a registered read.
// Kept separate so a vendor RAM macro can replace it.
module dram_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    wen,
    input  logic          ren,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (ren) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_ram_resp.sv
// Data-port responder: latches one request, waits WAIT_CYCLES, pulses ready.
// Define DRAM_ALIGN_CHECK_EN to reject misaligned/out-of-range requests.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready,
    output logic        stallreq,
    output logic        err
);

    dram_state_t          state;
    logic [DramWaitW-1:0] cnt;
    logic                 we_q;
    logic [AW-1:0]        idx_q;
    logic [3:0]           sel_q;
    logic [31:0]          wdata_q;
    logic                 bad_q;
    logic                 zero_q;
    logic [31:0]          rdata;

    logic                 bad_in;
    logic                 in_idle;
    logic                 go_resp;
    logic                 cur_we;
    logic                 cur_bad;
    logic [3:0]           cur_sel;
    logic [AW-1:0]        cur_idx;
    logic [31:0]          cur_wdata;
    logic [3:0]           wen;
    logic                 ren;

`ifdef DRAM_ALIGN_CHECK_EN
    assign bad_in = misaligned(addr[1:0], sel) || (addr[31:AW+2] != '0);
`else
    logic unused_addr;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
    assign bad_in      = 1'b0;
`endif

    // In IDLE the request comes straight from the ports (zero-wait case).
    assign in_idle   = (state == DramIdle);
    assign cur_we    = in_idle ? we : we_q;
    assign cur_sel   = in_idle ? sel : sel_q;
    assign cur_idx   = in_idle ? addr[AW+1:2] : idx_q;
    assign cur_wdata = in_idle ? data_i : wdata_q;
    assign cur_bad   = in_idle ? bad_in : bad_q;

    assign go_resp = (in_idle && ce && (WAIT_CYCLES == 0)) ||
                     ((state == DramWait) && ce && (cnt == DramWaitW'(1)));

    assign wen = (go_resp && cur_we && !cur_bad) ? cur_sel : 4'b0000;
    assign ren = go_resp && !cur_we && !cur_bad;

    dram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .addr  (cur_idx),
        .wen   (wen),
        .ren   (ren),
        .wdata (cur_wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state   <= DramIdle;
            cnt     <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            wdata_q <= ZeroWord;
            bad_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            ready <= go_resp;
            err   <= go_resp && cur_bad;
            case (state)
                DramIdle: begin
                    if (ce) begin
                        we_q    <= we;
                        idx_q   <= addr[AW+1:2];
                        sel_q   <= sel;
                        wdata_q <= data_i;
                        bad_q   <= bad_in;
                        if (WAIT_CYCLES == 0) begin
                            state <= DramResp;
                        end else begin
                            state <= DramWait;
                            cnt   <= DramWaitW'(WAIT_CYCLES);
                        end
                    end
                end
                DramWait: begin
                    if (!ce) begin
                        state <= DramIdle;
                        cnt   <= '0;
                    end else if (cnt == DramWaitW'(1)) begin
                        state <= DramResp;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DramResp: state <= DramIdle;
                default:  state <= DramIdle;
            endcase
            // data_o reads as zero until a good load, and after any rejection.
            if (ren) begin
                zero_q <= 1'b0;
            end else if (go_resp && cur_bad) begin
                zero_q <= 1'b1;
            end
        end
    end

    assign data_o   = zero_q ? ZeroWord : rdata;
    assign stallreq = ce & ~ready;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed, table-driven bench for data_ram_resp (WAIT_CYCLES=2 and 0).
// Checks latency, data, err, stallreq, abort and reset corner cases.
module tb_data_ram_resp;

`ifdef DRAM_ALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_a, ce_b;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o_a, data_o_b;
    logic        ready_a, ready_b;
    logic        stall_a, stall_b;
    logic        err_a, err_b;

    int checks = 0;
    int failures = 0;
    logic [31:0] held_a = 32'h0;
    logic [31:0] held_b = 32'h0;

    always #5 clk = ~clk;

    data_ram_resp #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .ce(ce_a), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o_a), .ready(ready_a),
        .stallreq(stall_a), .err(err_a)
    );

    data_ram_resp #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .ce(ce_b), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o_b), .ready(ready_b),
        .stallreq(stall_b), .err(err_b)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d,
                                input logic [31:0] exp, input logic e);
        vec_t v;
        v.w = w; v.a = a; v.s = s; v.d = d; v.exp = exp; v.exp_err = e;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic req(input int u, input vec_t v, input string nm);
        int lat;
        logic r, s, e;
        logic [31:0] q;
        @(negedge clk);
        we = v.w; addr = v.a; sel = v.s; data_i = v.d;
        if (u == 0) ce_a = 1'b1; else ce_b = 1'b1;
        lat = 0;
        r = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            r = (u == 0) ? ready_a : ready_b;
            s = (u == 0) ? stall_a : stall_b;
            if (!r) check({nm, " stall"}, {31'd0, s}, 32'd1);
        end while (!r && lat < 20);
        e = (u == 0) ? err_a : err_b;
        q = (u == 0) ? data_o_a : data_o_b;
        check({nm, " ready"}, {31'd0, r}, 32'd1);
        check({nm, " latency"}, lat, (u == 0) ? 32'd3 : 32'd1);
        check({nm, " stall@ready"}, {31'd0, s}, 32'd0);
        check({nm, " err"}, {31'd0, e}, {31'd0, v.exp_err});
        if (u == 0) begin
            if (v.exp_err) held_a = 32'h0;
            else if (!v.w) held_a = v.exp;
            check({nm, " data"}, q, held_a);
        end else begin
            if (v.exp_err) held_b = 32'h0;
            else if (!v.w) held_b = v.exp;
            check({nm, " data"}, q, held_b);
        end
        ce_a = 1'b0;
        ce_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce_a = 1'b0; ce_b = 1'b0; we = 1'b0;
        addr = '0; sel = '0; data_i = '0;

        tv.push_back(mk(1, 32'h10,   4'hF, 32'h11223344, 32'h0, 0));
        tv.push_back(mk(0, 32'h10,   4'hF, 32'h0, 32'h11223344, 0));
        tv.push_back(mk(1, 32'h10,   4'h4, 32'hAABBCCDD, 32'h0, 0));
        tv.push_back(mk(0, 32'h10,   4'hF, 32'h0, 32'h11BB3344, 0));
        tv.push_back(mk(1, 32'h20,   4'hF, 32'hCAFEBABE, 32'h0, 0));
        tv.push_back(mk(1, 32'h20,   4'h0, 32'h55667788, 32'h0, 0));
        tv.push_back(mk(0, 32'h20,   4'hF, 32'h0, 32'hCAFEBABE, 0));
        tv.push_back(mk(1, 32'h24,   4'hF, 32'h12345678, 32'h0, 0));
        tv.push_back(mk(1, 32'h1024, 4'hF, 32'h0BADF00D, 32'h0, CHK));
        tv.push_back(mk(0, 32'h24,   4'hF, 32'h0,
                        CHK ? 32'h12345678 : 32'h0BADF00D, 0));
        tv.push_back(mk(1, 32'h0,    4'hF, 32'h01020304, 32'h0, 0));
        tv.push_back(mk(1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0, CHK));
        tv.push_back(mk(0, 32'h0,    4'hF, 32'h0,
                        CHK ? 32'h01020304 : 32'hDEADBEEF, 0));
        tv.push_back(mk(0, 32'h12,   4'hF, 32'h0,
                        CHK ? 32'h0 : 32'h11BB3344, CHK));
        tv.push_back(mk(1, 32'h10,   4'h9, 32'hEE0000FF, 32'h0, 0));
        tv.push_back(mk(0, 32'h10,   4'hF, 32'h0, 32'hEEBB33FF, 0));

        // Reset state
        #2;
        check("rst ready", {31'd0, ready_a}, 32'd0);
        check("rst err", {31'd0, err_a}, 32'd0);
        check("rst data_o", data_o_a, 32'h0);
        check("rst stall idle", {31'd0, stall_a}, 32'd0);
        ce_a = 1'b1;
        #1;
        check("rst stall ce", {31'd0, stall_a}, 32'd1);
        ce_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            req(0, tv[i], $sformatf("vec%0d", i));
        end

        // Abort a store in its first WAIT cycle
        @(negedge clk);
        we = 1'b1; addr = 32'h10; sel = 4'hF; data_i = 32'hFFFFFFFF;
        ce_a = 1'b1;
        @(negedge clk);
        check("abort ready0", {31'd0, ready_a}, 32'd0);
        ce_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort no ready", {31'd0, ready_a}, 32'd0);
        end
        req(0, mk(0, 32'h10, 4'hF, 32'h0, 32'hEEBB33FF, 0), "after abort");

        // Reset asserted during WAIT drops the store
        @(negedge clk);
        we = 1'b1; addr = 32'h10; sel = 4'hF; data_i = 32'h77777777;
        ce_a = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst ready", {31'd0, ready_a}, 32'd0);
        check("midrst data_o", data_o_a, 32'h0);
        check("midrst err", {31'd0, err_a}, 32'd0);
        held_a = 32'h0;
        held_b = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        ce_a = 1'b0;
        req(0, mk(0, 32'h10, 4'hF, 32'h0, 32'hEEBB33FF, 0), "after midrst");

        // Zero-wait instance: fill, then back-to-back loads
        req(1, mk(1, 32'h10, 4'hF, 32'hA1A2A3A4, 32'h0, 0), "w0 st10");
        req(1, mk(1, 32'h14, 4'hF, 32'hB1B2B3B4, 32'h0, 0), "w0 st14");
        @(negedge clk);
        we = 1'b0; addr = 32'h10; sel = 4'hF; ce_b = 1'b1;
        @(negedge clk);
        check("b2b first ready", {31'd0, ready_b}, 32'd1);
        check("b2b first data", data_o_b, 32'hA1A2A3A4);
        addr = 32'h14;
        @(negedge clk);
        check("b2b gap ready", {31'd0, ready_b}, 32'd0);
        check("b2b gap stall", {31'd0, stall_b}, 32'd1);
        check("b2b gap hold", data_o_b, 32'hA1A2A3A4);
        @(negedge clk);
        check("b2b second ready", {31'd0, ready_b}, 32'd1);
        check("b2b second data", data_o_b, 32'hB1B2B3B4);
        ce_b = 1'b0;
        @(negedge clk);
        check("b2b end ready", {31'd0, ready_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
